hub_mult_out_buffer: RTL and testbench
======================================

HUB_MULT_OUT_BUFFER -- requirements
Module: hub_mult_out_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning HUB result width (E+M+1 of the multiplier format).
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of buffered results; legal values 2, 4, 8.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-006 SHALL have port in_valid_i  input  1  upstream multiplier result valid.
REQ-007 SHALL have port in_ready_o  output  1  buffer can accept a result.
REQ-008 SHALL have port result_i  input  WIDTH  multiplier result.
REQ-009 SHALL have port status_i  input  5  multiplier flags, bit order {NV,DZ,OF,UF,NX} MSB to LSB.
REQ-010 SHALL have port out_valid_o  output  1  head entry valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts head entry.
REQ-012 SHALL have port result_o  output  WIDTH  head entry result.
REQ-013 SHALL have port status_o  output  5  head entry flags.
REQ-014 SHALL have port fflags_o  output  5  sticky OR of flags of all retired entries.
REQ-015 SHALL have port fflags_clr_i  input  1  clear sticky flags.
REQ-016 SHALL have port count_o  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 SHALL implement a circular FIFO of DEPTH entries {result, status} with read pointer, write pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-018 SHALL drive in_ready_o = (count_o != DEPTH), derived from registered state only, with no combinational path from out_ready_i.
REQ-019 SHALL push when in_valid_i && in_ready_o && !flush_i, writing result_i/status_i at the write pointer.
REQ-020 SHALL pop when out_valid_o && out_ready_i && !flush_i, advancing the read pointer.
REQ-021 SHALL drive out_valid_o = (count_o != 0); no bypass, so minimum input-to-output latency is exactly 1 cycle.
REQ-022 SHALL drive result_o/status_o from the head entry when out_valid_o=1 and all-zero when out_valid_o=0.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL, when full, not accept input even if a pop occurs in the same cycle.
REQ-025 SHALL hold the head entry stable while out_valid_o=1 and out_ready_i=0.
REQ-026 SHALL, on flush_i=1, set count and both pointers to 0 next cycle, discarding any same-cycle push and pop; fflags_o is unaffected by the flush.
REQ-027 SHALL, on each pop, update fflags_o <= fflags_o | status of popped entry.
REQ-028 SHALL, on fflags_clr_i=1, set fflags_o to 0, or to the popped entry's status if a pop occurs in the same cycle.
REQ-029 SHALL not accumulate flags of entries discarded by flush.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, set count_o=0, pointers=0 and fflags_o=0, giving in_ready_o=1, out_valid_o=0, result_o=0 and status_o=0; rst_i has priority over flush_i, push and pop.
REQ-031 SHALL leave storage-array contents unreset; they are unobservable because outputs are masked when empty.

Verification
REQ-032 SHALL cover single transfer: push 0x3C00/5'b00001 with out_ready_i=1 -> out_valid_o=1 the next cycle with result_o=0x3C00; after pop, fflags_o=5'b00001 and count_o=0.
REQ-033 SHALL cover fill/backpressure: out_ready_i=0, push 0x1111 then 0x2222 -> count_o=2, in_ready_o=0; a third push with value 0x3333 is ignored; raising out_ready_i yields 0x1111 then 0x2222 in order.
REQ-034 SHALL cover full with simultaneous pop: while full, in_valid_i=1 and out_ready_i=1 -> one pop, no push, count_o=1.
REQ-035 SHALL cover wrap-around: stream 10 consecutive results 0x0001..0x000A with in_valid_i=1 and out_ready_i=1 -> all 10 emitted in order with no loss, and count_o stays <=1.
REQ-036 SHALL cover flush mid-operation: hold 2 entries with status 5'b10000, then assert flush_i with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, and fflags_o unchanged.
REQ-037 SHALL cover clear/pop collision and reset: with fflags_o=5'b00011, assert fflags_clr_i in the same cycle as a pop of status 5'b00100 -> fflags_o=5'b00100; then rst_i=1 with 1 entry held -> all outputs 0 and in_ready_o=1 next cycle.

Source files
------------

// File: rtl/hub_mult_out_buffer.sv
// Circular output buffer for HUB multiplier results, with sticky flag accumulation on retire.
// Latency: 1 cycle minimum from push to head (no bypass).
// Backpressure: in_ready_o drops only when full, from registered occupancy; a same-cycle pop does not free a slot.
module hub_mult_out_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           result_i,
    input  logic [4:0]                 status_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [4:0]       status;   // {NV,DZ,OF,UF,NX}
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      fflags;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready_o  = (count != CW'(DEPTH));
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    assign head        = mem[rd_ptr];
    assign result_o    = out_valid_o ? head.result : '0;
    assign status_o    = out_valid_o ? head.status : '0;
    assign fflags_o    = fflags;
    assign count_o     = count;

    // Storage is left unreset; outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{result: result_i, status: status_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fflags <= '0;
        end else begin
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_next(wr_ptr);
                if (pop)  rd_ptr <= ptr_next(rd_ptr);
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            // Clear wins over accumulation, but the entry retiring this cycle still counts.
            if (fflags_clr_i)  fflags <= pop ? head.status : '0;
            else if (pop)      fflags <= fflags | head.status;
        end
    end
endmodule

// File: tb/tb_hub_mult_out_buffer.sv
// Directed bench for hub_mult_out_buffer: driver queues expected results, a monitor retires them.
// Register state (count, flags, ready) is compared right after each clock edge.
module tb_hub_mult_out_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] result_i;
    logic [4:0]  status_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] result_o;
    logic [4:0]  status_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic [1:0]  count_o;

    typedef struct packed {
        logic [15:0] r;
        logic [4:0]  s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pops = 0;

    hub_mult_out_buffer #(.WIDTH(16), .DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .result_i     (result_i),
        .status_i     (status_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .result_o     (result_o),
        .status_o     (status_o),
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle with the given input; exp_rdy is the hand-derived in_ready for this cycle.
    task automatic drive_in(input logic v, input logic [15:0] r, input logic [4:0] s, input logic exp_rdy);
        in_valid_i = v;
        result_i   = r;
        status_i   = s;
        @(negedge clk_i);
        if (v) begin
            check("in_ready", {31'b0, in_ready_o}, {31'b0, exp_rdy});
            if (exp_rdy && !flush_i && !rst_i) exp_q.push_back('{r: r, s: s});
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", result_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_result", {16'b0, result_o}, {16'b0, e.r});
                check("out_status", {27'b0, status_o}, {27'b0, e.s});
            end
            n_pops++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; result_i = '0; status_i = '0;
        out_ready_i = 1'b0; fflags_clr_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_count",    count_o,     0);
        check("rst_in_ready", in_ready_o,  1);
        check("rst_out_vld",  out_valid_o, 0);
        check("rst_result",   result_o,    0);
        check("rst_status",   status_o,    0);
        check("rst_fflags",   fflags_o,    0);
        rst_i = 1'b0;

        // Single transfer
        out_ready_i = 1'b1;
        drive_in(1'b1, 16'h3C00, 5'b00001, 1'b1);
        check("t1_out_vld", out_valid_o, 1);
        check("t1_result",  result_o, 32'h3C00);
        drive_in(1'b0, 16'h0, 5'b0, 1'b1);
        check("t1_fflags", fflags_o, 5'b00001);
        check("t1_count",  count_o, 0);

        // Fill and backpressure
        out_ready_i = 1'b0;
        drive_in(1'b1, 16'h1111, 5'b0, 1'b1);
        drive_in(1'b1, 16'h2222, 5'b0, 1'b1);
        check("t2_count_full", count_o, 2);
        check("t2_in_ready",   in_ready_o, 0);
        drive_in(1'b1, 16'h3333, 5'b0, 1'b0);
        check("t2_count_hold", count_o, 2);
        check("t2_head_hold",  result_o, 32'h1111);

        // Full with simultaneous pop: pop only
        out_ready_i = 1'b1;
        drive_in(1'b1, 16'h3333, 5'b0, 1'b0);
        check("t3_count", count_o, 1);
        drive_in(1'b0, 16'h0, 5'b0, 1'b1);
        check("t3_empty", count_o, 0);

        // Streaming through wrap-around
        for (int i = 1; i <= 10; i++) begin
            drive_in(1'b1, 16'(i), 5'b0, 1'b1);
            check("t4_count", count_o, 1);
        end
        drive_in(1'b0, 16'h0, 5'b0, 1'b1);
        check("t4_drained", count_o, 0);

        // Flush with two held entries, same-cycle push and pop discarded
        out_ready_i = 1'b0;
        drive_in(1'b1, 16'hAAAA, 5'b10000, 1'b1);
        drive_in(1'b1, 16'hBBBB, 5'b10000, 1'b1);
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        drive_in(1'b1, 16'hCCCC, 5'b0, 1'b0);
        flush_i = 1'b0;
        exp_q.delete();
        check("t5_count",   count_o, 0);
        check("t5_out_vld", out_valid_o, 0);
        check("t5_result",  result_o, 0);
        check("t5_fflags",  fflags_o, 5'b00001);

        // Flush discards a push that would otherwise be accepted
        out_ready_i = 1'b0;
        drive_in(1'b1, 16'hDDDD, 5'b01000, 1'b1);
        flush_i = 1'b1;
        drive_in(1'b1, 16'hEEEE, 5'b0, 1'b1);
        flush_i = 1'b0;
        exp_q.delete();
        check("t6_count",  count_o, 0);
        check("t6_fflags", fflags_o, 5'b00001);

        // Clear, then clear colliding with a pop
        fflags_clr_i = 1'b1;
        drive_in(1'b0, 16'h0, 5'b0, 1'b1);
        fflags_clr_i = 1'b0;
        check("t7_cleared", fflags_o, 0);
        out_ready_i = 1'b1;
        drive_in(1'b1, 16'h0101, 5'b00011, 1'b1);
        drive_in(1'b0, 16'h0, 5'b0, 1'b1);
        check("t7_fflags_acc", fflags_o, 5'b00011);
        out_ready_i = 1'b0;
        drive_in(1'b1, 16'h0202, 5'b00100, 1'b1);
        out_ready_i = 1'b1;
        fflags_clr_i = 1'b1;
        drive_in(1'b0, 16'h0, 5'b0, 1'b1);
        fflags_clr_i = 1'b0;
        check("t7_clr_pop", fflags_o, 5'b00100);

        // Reset with one entry held
        out_ready_i = 1'b0;
        drive_in(1'b1, 16'h0303, 5'b00010, 1'b1);
        check("t8_held", count_o, 1);
        rst_i = 1'b1;
        drive_in(1'b0, 16'h0, 5'b0, 1'b1);
        rst_i = 1'b0;
        exp_q.delete();
        check("t8_count",    count_o, 0);
        check("t8_in_ready", in_ready_o, 1);
        check("t8_out_vld",  out_valid_o, 0);
        check("t8_result",   result_o, 0);
        check("t8_status",   status_o, 0);
        check("t8_fflags",   fflags_o, 0);

        check("pop_total",   n_pops, 15);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
